// File: rtl/pulse_count_multi.sv
// Multi-channel pulse counter with a shared programmable terminal count,
// per-channel wrap/one-shot behaviour and an atomic snapshot readback.
module pulse_count_multi #(
    parameter int CH          = 4,
    parameter int COUNT_WIDTH = 16,
    parameter int EDGE_MODE   = 1,
    localparam int SEL_W      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [CH-1:0]          i_pulse,
    input  logic                   i_enable,
    input  logic                   i_clear,
    input  logic                   i_mode,
    input  logic [COUNT_WIDTH-1:0] i_terminal,
    input  logic                   i_snap,
    input  logic [SEL_W-1:0]       i_snap_sel,
    output logic [COUNT_WIDTH-1:0] o_snap_data,
    output logic                   o_snap_valid,
    output logic [CH-1:0]          o_count_equal,
    output logic [CH-1:0]          o_done
);

    localparam logic [COUNT_WIDTH-1:0] ONE  = COUNT_WIDTH'(1);
    localparam logic [SEL_W:0]         CH_L = (SEL_W + 1)'(CH);

    logic [CH-1:0]          r_pulse_q;
    logic [CH-1:0]          r_pulse_q2;
    logic [COUNT_WIDTH-1:0] r_count  [CH];
    logic [COUNT_WIDTH-1:0] r_shadow [CH];
    logic [CH-1:0]          r_done;
    logic [CH-1:0]          r_count_equal;
    logic                   r_snap_valid;

    logic [CH-1:0]          w_event;
    logic [CH-1:0]          w_count_en;
    logic                   w_term_zero;
    logic [COUNT_WIDTH-1:0] w_term_m1;
    logic [COUNT_WIDTH-1:0] w_count_nxt [CH];
    logic [CH-1:0]          w_hit_nxt;
    logic [CH-1:0]          w_done_nxt;

    generate
        if (EDGE_MODE != 0) begin : g_edge
            assign w_event = r_pulse_q & ~r_pulse_q2;
        end else begin : g_level
            assign w_event = r_pulse_q;
        end
    endgenerate

    // A channel that has finished its one-shot ignores events until clear/reset.
    assign w_count_en  = w_event & {CH{i_enable}} & ~r_done;
    assign w_term_zero = (i_terminal == '0);
    assign w_term_m1   = i_terminal - ONE;

    // The >= compare makes a terminal lowered below a running count hit on
    // the very next event instead of running out the full counter range.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            w_count_nxt[i] = r_count[i];
            w_hit_nxt[i]   = 1'b0;
            w_done_nxt[i]  = r_done[i];
            if (w_count_en[i]) begin
                if (w_term_zero) begin
                    w_count_nxt[i] = r_count[i] + ONE;
                    w_hit_nxt[i]   = &r_count[i];
                end else if (r_count[i] >= w_term_m1) begin
                    w_hit_nxt[i] = 1'b1;
                    if (i_mode) begin
                        w_count_nxt[i] = i_terminal;
                        w_done_nxt[i]  = 1'b1;
                    end else begin
                        w_count_nxt[i] = '0;
                    end
                end else begin
                    w_count_nxt[i] = r_count[i] + ONE;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pulse_q     <= '0;
            r_pulse_q2    <= '0;
            r_done        <= '0;
            r_count_equal <= '0;
            r_snap_valid  <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                r_count[i]  <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_pulse_q    <= i_pulse;
            r_pulse_q2   <= r_pulse_q;
            r_snap_valid <= i_snap;
            // Shadows take the pre-edge counts, so a same-edge event or clear is not seen.
            if (i_snap) begin
                for (int i = 0; i < CH; i++) begin
                    r_shadow[i] <= r_count[i];
                end
            end
            if (i_clear) begin
                r_done        <= '0;
                r_count_equal <= '0;
                for (int i = 0; i < CH; i++) begin
                    r_count[i] <= '0;
                end
            end else begin
                r_done        <= w_done_nxt;
                r_count_equal <= w_hit_nxt;
                for (int i = 0; i < CH; i++) begin
                    r_count[i] <= w_count_nxt[i];
                end
            end
        end
    end

    always_comb begin
        o_snap_data = '0;
        if ({1'b0, i_snap_sel} < CH_L) begin
            o_snap_data = r_shadow[i_snap_sel];
        end
    end

    assign o_snap_valid  = r_snap_valid;
    assign o_count_equal = r_count_equal;
    assign o_done        = r_done;

endmodule

// File: tb/tb_pulse_count_multi.sv
// Bench for pulse_count_multi: a 4-channel 16-bit edge-mode instance and a
// 3-channel 4-bit level-mode instance, checked against arithmetic expectations.
module tb_pulse_count_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        mode = 1'b0;
    logic        snap = 1'b0;
    logic [3:0]  pulse = '0;
    logic [15:0] terminal = '0;
    logic [1:0]  snap_sel = '0;
    logic [15:0] snap_data;
    logic        snap_valid;
    logic [3:0]  count_equal;
    logic [3:0]  done;

    logic [2:0]  p2_pulse = '0;
    logic [3:0]  p2_terminal = '0;
    logic [1:0]  p2_sel = '0;
    logic [3:0]  p2_data;
    logic        p2_valid;
    logic [2:0]  p2_ceq;
    logic [2:0]  p2_done;

    int tests_run = 0;
    int tests_failed = 0;
    int ceq_cnt[4]  = '{default: 0};
    int ceq2_cnt[3] = '{default: 0};
    logic [15:0] rd[4];
    logic [3:0]  rd2[3];

    pulse_count_multi #(.CH(4), .COUNT_WIDTH(16), .EDGE_MODE(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pulse(pulse), .i_enable(enable),
        .i_clear(clear), .i_mode(mode), .i_terminal(terminal), .i_snap(snap),
        .i_snap_sel(snap_sel), .o_snap_data(snap_data), .o_snap_valid(snap_valid),
        .o_count_equal(count_equal), .o_done(done)
    );

    pulse_count_multi #(.CH(3), .COUNT_WIDTH(4), .EDGE_MODE(0)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pulse(p2_pulse), .i_enable(enable),
        .i_clear(clear), .i_mode(mode), .i_terminal(p2_terminal), .i_snap(snap),
        .i_snap_sel(p2_sel), .o_snap_data(p2_data), .o_snap_valid(p2_valid),
        .o_count_equal(p2_ceq), .o_done(p2_done)
    );

    // Count every strobe cycle; tests look at the change across a scenario.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (count_equal[i] === 1'b1) ceq_cnt[i]++;
        for (int i = 0; i < 3; i++) if (p2_ceq[i] === 1'b1) ceq2_cnt[i]++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mask(input logic [3:0] m);
        pulse = m;
        tick();
        pulse = '0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic snap_all();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            snap_sel = 2'(i);
            p2_sel   = 2'(i);
            #1;
            rd[i] = snap_data;
            if (i < 3) rd2[i] = p2_data;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        snap   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pulse    = 4'($urandom);
            p2_pulse = 3'($urandom);
            tick();
        end
        snap = 1'b0;
        tests_run++;
        if (count_equal !== 4'b0 || done !== 4'b0 || snap_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got ceq=%b done=%b sv=%b exp 0", count_equal, done, snap_valid);
        end
        for (int i = 0; i < 4; i++) begin
            snap_sel = 2'(i);
            #1;
            tests_run++;
            if (snap_data !== 16'd0) begin
                tests_failed++;
                $display("FAIL reset_snap_data sel=%0d got=%0d exp=0", i, snap_data);
            end
        end
        pulse = '0;
        p2_pulse = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pulse_mask(4'b0010);
        snap_all();
        tests_run++;
        if (rd[1] !== 16'd1 || rd[0] !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_first_edge got ch1=%0d ch0=%0d exp 1/0", rd[1], rd[0]);
        end
        pulse_mask(4'b0010);
        rst_n = 1'b0;
        tick();
        snap_all();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (rd[1] !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_count got=%0d exp=0", rd[1]);
        end
    endtask

    task automatic test_wrap();
        int base;
        mode = 1'b0;
        terminal = 16'd1;
        do_clear();
        pulse = 4'b0001;
        tick();
        pulse = '0;
        tests_run++;
        if (count_equal !== 4'b0000) begin
            tests_failed++;
            $display("FAIL latency_early got=%b exp=0000", count_equal);
        end
        tick();
        tests_run++;
        if (count_equal !== 4'b0001) begin
            tests_failed++;
            $display("FAIL latency_strobe got=%b exp=0001", count_equal);
        end
        tick();
        tests_run++;
        if (count_equal !== 4'b0000) begin
            tests_failed++;
            $display("FAIL latency_single got=%b exp=0000", count_equal);
        end
        terminal = 16'd5;
        do_clear();
        base = ceq_cnt[0];
        for (int k = 1; k <= 12; k++) begin
            pulse_mask(4'b0001);
            tests_run++;
            if (count_equal !== ((k % 5 == 0) ? 4'b0001 : 4'b0000)) begin
                tests_failed++;
                $display("FAIL wrap_strobe pulse=%0d got=%b", k, count_equal);
            end
        end
        snap_all();
        tests_run++;
        if (ceq_cnt[0] - base !== 2) begin
            tests_failed++;
            $display("FAIL wrap_strobe_count got=%0d exp=2", ceq_cnt[0] - base);
        end
        tests_run++;
        if (rd[0] !== 16'd2 || rd[1] !== 16'd0 || rd[2] !== 16'd0 || rd[3] !== 16'd0) begin
            tests_failed++;
            $display("FAIL wrap_counts got %0d/%0d/%0d/%0d exp 2/0/0/0", rd[0], rd[1], rd[2], rd[3]);
        end
    endtask

    task automatic test_oneshot();
        int base;
        mode = 1'b1;
        terminal = 16'd3;
        do_clear();
        base = ceq_cnt[2];
        repeat (6) pulse_mask(4'b0100);
        snap_all();
        tests_run++;
        if (ceq_cnt[2] - base !== 1 || done !== 4'b0100 || rd[2] !== 16'd3) begin
            tests_failed++;
            $display("FAIL oneshot got strobes=%0d done=%b count=%0d exp 1/0100/3", ceq_cnt[2] - base, done, rd[2]);
        end
        mode = 1'b0;
        pulse_mask(4'b0100);
        snap_all();
        tests_run++;
        if (done !== 4'b0100 || rd[2] !== 16'd3) begin
            tests_failed++;
            $display("FAIL oneshot_mode_change got done=%b count=%0d exp 0100/3", done, rd[2]);
        end
        do_clear();
        snap_all();
        tests_run++;
        if (done !== 4'b0000 || rd[2] !== 16'd0) begin
            tests_failed++;
            $display("FAIL oneshot_clear got done=%b count=%0d exp 0000/0", done, rd[2]);
        end
    endtask

    task automatic test_freerun();
        int base;
        mode = 1'b0;
        p2_terminal = 4'd0;
        do_clear();
        base = ceq2_cnt[0];
        p2_pulse = 3'b001;
        for (int k = 1; k <= 17; k++) begin
            tick();
            // level sampled at edge k becomes event k, consumed one edge later
            tests_run++;
            if (p2_ceq[0] !== (k == 17)) begin
                tests_failed++;
                $display("FAIL freerun_strobe cycle=%0d got=%b", k, p2_ceq[0]);
            end
        end
        p2_pulse = '0;
        tick();
        tick();
        snap_all();
        tests_run++;
        if (ceq2_cnt[0] - base !== 1 || rd2[0] !== 4'd1) begin
            tests_failed++;
            $display("FAIL freerun got strobes=%0d count=%0d exp 1/1", ceq2_cnt[0] - base, rd2[0]);
        end
        p2_sel = 2'd3;
        #1;
        tests_run++;
        if (p2_data !== 4'd0) begin
            tests_failed++;
            $display("FAIL sel_out_of_range got=%0d exp=0", p2_data);
        end
        p2_terminal = 4'd1;
        do_clear();
        base = ceq2_cnt[1];
        p2_pulse = 3'b010;
        repeat (5) tick();
        p2_pulse = '0;
        tick();
        tick();
        tests_run++;
        if (ceq2_cnt[1] - base !== 5) begin
            tests_failed++;
            $display("FAIL level_t1_strobes got=%0d exp=5", ceq2_cnt[1] - base);
        end
    endtask

    task automatic test_collisions();
        mode = 1'b0;
        terminal = 16'd1;
        do_clear();
        pulse = 4'b1000;
        tick();
        pulse = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests_run++;
        if (count_equal !== 4'b0000) begin
            tests_failed++;
            $display("FAIL clear_vs_event_strobe got=%b exp=0000", count_equal);
        end
        snap_all();
        tests_run++;
        if (rd[3] !== 16'd0) begin
            tests_failed++;
            $display("FAIL clear_vs_event_count got=%0d exp=0", rd[3]);
        end
        terminal = 16'd10;
        repeat (7) pulse_mask(4'b0010);
        terminal = 16'd4;
        pulse_mask(4'b0010);
        tests_run++;
        if (count_equal !== 4'b0010) begin
            tests_failed++;
            $display("FAIL lower_terminal_strobe got=%b exp=0010", count_equal);
        end
        snap_all();
        tests_run++;
        if (rd[1] !== 16'd0) begin
            tests_failed++;
            $display("FAIL lower_terminal_count got=%0d exp=0", rd[1]);
        end
        enable = 1'b0;
        pulse_mask(4'b0010);
        enable = 1'b1;
        tick();
        tick();
        snap_all();
        tests_run++;
        if (rd[1] !== 16'd0) begin
            tests_failed++;
            $display("FAIL enable_low_edge got=%0d exp=0", rd[1]);
        end
        pulse_mask(4'b0010);
        snap_all();
        tests_run++;
        if (rd[1] !== 16'd1) begin
            tests_failed++;
            $display("FAIL enable_restored got=%0d exp=1", rd[1]);
        end
    endtask

    task automatic test_snapshot();
        int exp_s[4] = '{3, 7, 0, 9};
        mode = 1'b0;
        terminal = 16'd0;
        do_clear();
        for (int k = 0; k < 9; k++) begin
            pulse_mask({1'b1, 1'b0, (k < 7), (k < 3)});
        end
        snap = 1'b1;
        tick();
        snap = 1'b0;
        tests_run++;
        if (snap_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL snap_valid_high got=%b exp=1", snap_valid);
        end
        tick();
        tests_run++;
        if (snap_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL snap_valid_once got=%b exp=0", snap_valid);
        end
        repeat (2) pulse_mask(4'b1011);
        for (int i = 0; i < 4; i++) begin
            snap_sel = 2'(i);
            #1;
            tests_run++;
            if (snap_data !== 16'(exp_s[i])) begin
                tests_failed++;
                $display("FAIL snapshot_hold sel=%0d got=%0d exp=%0d", i, snap_data, exp_s[i]);
            end
        end
    endtask

    task automatic test_random();
        int n[4];
        int base[4];
        int t, ec, es, steps;
        logic m, ed;
        logic [3:0] mask;
        for (int r = 0; r < 8; r++) begin
            t = $urandom_range(0, 8);
            m = 1'($urandom_range(0, 1));
            terminal = 16'(t);
            mode = m;
            do_clear();
            for (int i = 0; i < 4; i++) begin
                n[i] = 0;
                base[i] = ceq_cnt[i];
            end
            steps = $urandom_range(5, 25);
            for (int s = 0; s < steps; s++) begin
                mask = 4'($urandom_range(0, 15));
                pulse_mask(mask);
                for (int i = 0; i < 4; i++) n[i] += int'(mask[i]);
            end
            tick();
            snap_all();
            for (int i = 0; i < 4; i++) begin
                if (t == 0) begin
                    ec = n[i] % 65536; es = 0; ed = 1'b0;
                end else if (!m) begin
                    ec = n[i] % t; es = n[i] / t; ed = 1'b0;
                end else begin
                    ed = (n[i] >= t); ec = ed ? t : n[i]; es = int'(ed);
                end
                tests_run++;
                if (rd[i] !== 16'(ec) || ceq_cnt[i] - base[i] !== es || done[i] !== ed) begin
                    tests_failed++;
                    $display("FAIL random r=%0d ch=%0d T=%0d mode=%b n=%0d got cnt=%0d str=%0d done=%b exp %0d/%0d/%b",
                             r, i, t, m, n[i], rd[i], ceq_cnt[i] - base[i], done[i], ec, es, ed);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_oneshot();
        test_freerun();
        test_collisions();
        test_snapshot();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
